// File: rtl/instr_loader.sv
// Byte-serial program loader: takes a length-prefixed, big-endian byte stream and
// writes one 32-bit instruction word per four bytes, holding the CPU in reset until done.
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        cpuHold,
  output logic        done,
  output logic        error,
  output logic [15:0] wordCount
);

  localparam int unsigned LenW   = 16;
  localparam int unsigned WordW  = 32;
  localparam int unsigned IdxW   = 2;
  localparam logic [LenW-1:0] MaxLen = LenW'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_e;

  state_e               state_q, state_d;
  logic [LenW-1:0]      len_q, len_d;
  logic [WordW-1:0]     word_q, word_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [LenW-1:0]      count_q, count_d;

  logic                 ready_c;
  logic                 xfer_c;
  logic [LenW-1:0]      len_full_c;
  logic [LenW-1:0]      count_inc_c;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Ready depends on state alone so a source may hold its byte across a WRITE stall
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA: ready_c = 1'b1;
      default:                    ready_c = 1'b0;
    endcase
  end

  assign xfer_c      = byteValid && ready_c;
  assign len_full_c  = {len_q[15:8], byteIn};
  assign count_inc_c = LenW'(count_q + 16'd1);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    idx_d   = idx_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          count_d = '0;
          idx_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer_c) begin
          len_d[15:8] = byteIn;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer_c) begin
          len_d[7:0] = byteIn;
          if (len_full_c == '0) begin
            state_d = S_DONE;
          end else if (len_full_c > MaxLen) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          word_d = {word_q[23:0], byteIn};
          idx_d  = IdxW'(idx_q + 2'd1);
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        count_d = count_inc_c;
        if (count_inc_c == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from registered state and data
  always_comb begin
    byteReady    = ready_c;
    memWrite     = (state_q == S_WRITE);
    memAddress   = BASE_ADDR + WordW'({count_q, 2'b00});
    memWriteData = word_q;
    cpuHold      = (state_q != S_DONE);
    done         = (state_q == S_DONE);
    error        = (state_q == S_ERROR);
    wordCount    = count_q;
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader against a word-level reference model.
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        cpuHold;
  logic        done;
  logic        error;
  logic [15:0] wordCount;

  instr_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .start(start), .byteIn(byteIn),
    .byteValid(byteValid), .byteReady(byteReady), .memWrite(memWrite),
    .memAddress(memAddress), .memWriteData(memWriteData), .cpuHold(cpuHold),
    .done(done), .error(error), .wordCount(wordCount)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  bit          held_in_write;
  bit          ready_in_write;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one load: start pulse, then the byte stream. Samples on negedges.
  task automatic run_load(input string tag, input int n, input bit gaps,
                          input int abort_after, output int cycles);
    logic [7:0] q[$];
    int  idx;
    bit  drove;
    bit  rdy;
    bit  ended;
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    if (n >= 1 && n <= MAXW) begin
      for (int i = 0; i < n; i++) begin
        q.push_back(prog[i][31:24]);
        q.push_back(prog[i][23:16]);
        q.push_back(prog[i][15:8]);
        q.push_back(prog[i][7:0]);
      end
    end
    obs_addr.delete();
    obs_data.delete();
    held_in_write  = 1'b0;
    ready_in_write = 1'b0;
    @(negedge clock);
    start = 1'b1;
    byteValid = 1'b0;
    @(negedge clock);
    start = 1'b0;
    cycles = 1;
    idx = 0;
    drove = 1'b0;
    rdy = 1'b0;
    ended = 1'b0;
    check({tag, "/lenhi_ready"}, 32'(byteReady), 32'd1);
    check({tag, "/lenhi_error"}, 32'(error), 32'd0);
    for (int c = 0; c < 20000; c++) begin
      if (drove && rdy) idx++;
      if (memWrite) begin
        obs_addr.push_back(memAddress);
        obs_data.push_back(memWriteData);
        if (byteReady) ready_in_write = 1'b1;
      end
      if (done || error || (abort_after >= 0 && idx >= abort_after)) begin
        ended = 1'b1;
        break;
      end
      drove = 1'b0;
      if (idx < q.size() && (!gaps || memWrite || $urandom_range(0, 2) != 0)) begin
        byteValid = 1'b1;
        byteIn = q[idx];
        drove = 1'b1;
        if (memWrite) held_in_write = 1'b1;
      end else begin
        byteValid = 1'b0;
        byteIn = 8'($urandom);
      end
      rdy = byteReady;
      @(negedge clock);
      cycles++;
    end
    byteValid = 1'b0;
    check({tag, "/terminated"}, 32'(ended), 32'd1);
  endtask

  // Reference model: a load either completes with n writes at consecutive word addresses,
  // completes empty, or is rejected with no writes.
  task automatic verify(input string tag, input int n, input bit gaps, input int cycles);
    bit exp_err;
    int nw;
    exp_err = (n > MAXW);
    nw = exp_err ? 0 : n;
    check({tag, "/done"}, 32'(done), 32'(!exp_err));
    check({tag, "/error"}, 32'(error), 32'(exp_err));
    check({tag, "/cpuHold"}, 32'(cpuHold), 32'(exp_err));
    check({tag, "/wordCount"}, 32'(wordCount), 32'(nw));
    check({tag, "/nwrites"}, 32'(obs_addr.size()), 32'(nw));
    if (exp_err) check({tag, "/err_ready"}, 32'(byteReady), 32'd0);
    for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
      check($sformatf("%s/addr%0d", tag, i), obs_addr[i], BASE + 32'(4 * i));
      check($sformatf("%s/data%0d", tag, i), obs_data[i], prog[i]);
    end
    check({tag, "/ready_in_write"}, 32'(ready_in_write), 32'd0);
    if (!gaps) check({tag, "/cycles"}, 32'(cycles), 32'(exp_err ? 3 : 3 + 5 * n));
    if (gaps && nw > 0) check({tag, "/held_in_write"}, 32'(held_in_write), 32'd1);
  endtask

  task automatic random_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/byteReady"}, 32'(byteReady), 32'd0);
    check({tag, "/memWrite"}, 32'(memWrite), 32'd0);
    check({tag, "/memAddress"}, memAddress, BASE);
    check({tag, "/memWriteData"}, memWriteData, 32'd0);
    check({tag, "/cpuHold"}, 32'(cpuHold), 32'd1);
    check({tag, "/done"}, 32'(done), 32'd0);
    check({tag, "/error"}, 32'(error), 32'd0);
    check({tag, "/wordCount"}, 32'(wordCount), 32'd0);
  endtask

  initial begin
    int cyc;
    int n;
    reset = 1'b0;
    start = 1'b0;
    byteValid = 1'b0;
    byteIn = 8'h00;
    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_ready", 32'(byteReady), 32'd0);
    check("idle_hold", 32'(cpuHold), 32'd1);

    prog.delete();
    prog.push_back(32'h2008_0005);
    prog.push_back(32'h8C09_0004);
    run_load("two", 2, 1'b0, -1, cyc);
    verify("two", 2, 1'b0, cyc);

    run_load("empty", 0, 1'b0, -1, cyc);
    verify("empty", 0, 1'b0, cyc);

    run_load("oversize", 257, 1'b0, -1, cyc);
    verify("oversize", 257, 1'b0, cyc);
    repeat (3) @(negedge clock);
    check("oversize_sticky", 32'(error), 32'd1);

    run_load("two_gap", 2, 1'b1, -1, cyc);
    verify("two_gap", 2, 1'b1, cyc);

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 8));
      random_prog(n);
      run_load($sformatf("rnd%0d", r), n, r[0], -1, cyc);
      verify($sformatf("rnd%0d", r), n, r[0], cyc);
    end

    random_prog(MAXW);
    run_load("max", MAXW, 1'b0, -1, cyc);
    verify("max", MAXW, 1'b0, cyc);

    random_prog(3);
    run_load("abort", 3, 1'b0, 2 + 6, cyc);
    check("abort/nwrites", 32'(obs_addr.size()), 32'd1);
    if (obs_addr.size() > 0) begin
      check("abort/addr0", obs_addr[0], BASE);
      check("abort/data0", obs_data[0], prog[0]);
    end
    #2 reset = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_ready", 32'(byteReady), 32'd0);

    random_prog(1);
    run_load("reload", 1, 1'b0, -1, cyc);
    verify("reload", 1, 1'b0, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-serial program loader that writes 32-bit instruction words into the pipeline's instruction memory before execution. It is the write side of the instruction-memory port that the fetch stage reads: it receives a length-prefixed byte stream, assembles big-endian words, and issues one memory write per word. It holds the CPU in reset until a complete program has been stored.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; word-aligned.
- MAX_WORDS, 256: largest accepted word count; must be ≥1 and ≤65535.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byteIn  in  8  stream byte.
- byteValid  in  1  byteIn is valid this cycle.
- byteReady  out  1  loader accepts a byte this cycle.
- memWrite  out  1  instruction-memory write strobe, one cycle per word.
- memAddress  out  32  byte address of the write: BASE_ADDR + 4*index.
- memWriteData  out  32  assembled instruction word.
- cpuHold  out  1  holds the CPU in reset; high in every state except DONE.
- done  out  1  high while in DONE.
- error  out  1  high while in ERROR.
- wordCount  out  16  number of words written in the current or last load.

## Operation
- A byte transfers on a rising edge with byteValid && byteReady. byteReady is a function of state only, never of byteValid.
- States:
  - IDLE: initial state; no byte acceptance.
  - LEN_HI: accepts the high byte of N.
  - LEN_LO: accepts the low byte of N.
  - DATA: accepts word bytes.
  - WRITE: strobes the memory write.
  - DONE: load complete.
  - ERROR: load rejected.
- IDLE/DONE/ERROR + start → LEN_HI. On that edge, clear wordCount and the byte index. start in any other state is ignored.
- LEN_HI: on transfer, store N[15:8] → LEN_LO.
- LEN_LO: on transfer, store N[7:0], then:
  - N == 0 → DONE.
  - N > MAX_WORDS → ERROR.
  - otherwise → DATA.
- DATA: each transfer shifts the byte into the word register, first byte into bits [31:24]. The fourth transfer → WRITE.
- WRITE (exactly one cycle):
  - Outputs: memWrite=1, memAddress=BASE_ADDR+4*wordCount, memWriteData = assembled word.
  - On exit: wordCount increments. If the new wordCount == N → DONE, else → DATA.
- byteReady: 1 in LEN_HI, LEN_LO and DATA; 0 in IDLE, WRITE, DONE and ERROR.
- ERROR is sticky until start or reset. wordCount stays 0 in ERROR.
- memAddress arithmetic is 32-bit modulo. The range check guarantees no wrap when BASE_ADDR + 4*MAX_WORDS ≤ 2^32.
- Outputs are Moore, decoded from registered state and data.

## Timing
- Reset (asynchronous assert, any cycle, including mid-load) puts all outputs in their reset state:
  - state=IDLE, byteReady=0, memWrite=0, memAddress=BASE_ADDR.
  - memWriteData=0, cpuHold=1, done=0, error=0, wordCount=0.
  - A partially loaded program is abandoned; already-written words are not erased.
- Release of reset is synchronous to clock. The first possible transition is on the first edge after deassertion.
- Latency: memWrite is high in the cycle immediately after the edge that accepted the 4th byte of a word.
- Each word takes at least 5 cycles. The minimum load is 1 (start) + 2 + 5N cycles to DONE.
- cpuHold falls and done rises in the same cycle as entry to DONE. That is the cycle after the final WRITE, or the cycle after the LEN_LO transfer when N == 0.
- Gaps in byteValid stall the loader in place, with no timeout. Bytes presented during WRITE are not accepted and must be held by the source.
- start coinciding with the LEN_LO→DONE or WRITE→DONE edge is ignored, because the loader is not yet in DONE.

## Test plan
- Reset values: assert reset mid-cycle with clock running → all outputs at their reset values immediately, before the next edge. After release, byteReady=0 until start.
- Two-word load (BASE_ADDR=0):
  - Stimulus: start, then bytes 00 02 20 08 00 05 8C 09 00 04, byteValid held high.
  - Writes: write 0x20080005 to address 0x0, then 0x8C090004 to address 0x4, each memWrite exactly one cycle.
  - End state: DONE 13 cycles after start, wordCount=2, cpuHold=0.
- Empty program: start, then 00 00 → DONE the cycle after the second byte, no memWrite, wordCount=0.
- Oversize (MAX_WORDS=256): start, then 01 01 → ERROR, error=1, byteReady=0, no writes. A later start → LEN_HI with error=0.
- Back-pressure and gaps: toggle byteValid randomly and present a byte during WRITE → that byte is not consumed. Written data and addresses are identical to the ungapped run.
- Reset mid-load, then reload: pulse reset after 6 data bytes → IDLE with wordCount=0 and cpuHold=1. A subsequent full load of 1 word writes address BASE_ADDR and reaches DONE.
